// File: rtl/quadrature_encoder_x4.sv
// ---------------------------------------------------------------------------
// quadrature_encoder_x4
//
// Purpose:
//   x4 quadrature decoder with an Avalon-MM register interface. The A/B/Z
//   encoder pins are synchronised and glitch-filtered, then decoded into a
//   signed up/down position counter. A rising edge on Z latches the position
//   and can optionally clear it. Illegal transitions (both A and B changing
//   at once) are flagged and counted.
//
// Parameters:
//   CNT_WIDTH   - position counter width (2..32), read back sign-extended
//   SYNC_STAGES - synchroniser depth on A/B/Z (>=2)
//   FILTER_LEN  - consecutive differing samples needed to move a filtered pin
//   ID_VALUE    - constant returned at address 0
//
// Ports:
//   csi_MCLK_clk          system clock
//   rsi_MRST_reset        asynchronous active-high reset
//   avs_ctrl_*            Avalon-MM slave (1-cycle registered read, no wait)
//   A, B, Z               asynchronous encoder inputs
//   ins_irq_irq           interrupt (only with QUADRATURE_ENCODER_X4_IRQ_EN)
//
// Register map (word addresses):
//   0 ID, 1 CTRL {SOFT_CLR,INVERT_DIR,Z_CLEAR_EN,ENABLE}, 2 POSITION,
//   3 INDEX_LATCH, 4 STATUS {QERR,INDEX_SEEN,DIR}, 5 ERR_COUNT,
//   6 IRQ_MASK (bits 2:1, only with QUADRATURE_ENCODER_X4_IRQ_EN), 7 reads 0.
//
// Build option:
//   `define QUADRATURE_ENCODER_X4_IRQ_EN adds the interrupt port and mask.
// ---------------------------------------------------------------------------
module quadrature_encoder_x4 #(
   parameter int          CNT_WIDTH   = 16,
   parameter int          SYNC_STAGES = 2,
   parameter int          FILTER_LEN  = 4,
   parameter logic [31:0] ID_VALUE    = 32'hEA680004
) (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [31:0] avs_ctrl_writedata,
   output logic [31:0] avs_ctrl_readdata,
   input  logic [3:0]  avs_ctrl_byteenable,
   input  logic [2:0]  avs_ctrl_address,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   output logic        avs_ctrl_waitrequest,
   input  logic        A,
   input  logic        B,
   input  logic        Z
`ifdef QUADRATURE_ENCODER_X4_IRQ_EN
   ,
   output logic        ins_irq_irq
`endif
);

   localparam int FCW = $clog2(FILTER_LEN + 1);

   // Pin bundle, index 0 = A, 1 = B, 2 = Z
   logic [2:0]             pins;
   logic [SYNC_STAGES-1:0] sync_q [3];
   logic [2:0]             syncOut;
   logic [FCW-1:0]         fcnt_q [3];
   logic [2:0]             filt_q;

   logic [1:0]             prevAB_q;
   logic                   zPrev_q;

   logic [2:0]             ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0]   position_q, position_d;
   logic [CNT_WIDTH-1:0]   indexLatch_q, indexLatch_d;
   logic                   dir_q, dir_d;
   logic                   indexSeen_q, indexSeen_d;
   logic                   qerr_q, qerr_d;
   logic [15:0]            errCount_q, errCount_d;
   logic [31:0]            readdata_q, readMux;

   logic [1:0]             curAB;
   logic                   enable, zClearEn, invertDir;
   logic                   bothChg, oneChg, stepEn, errEv, zRise, countUp, zClear;
   logic                   wrCtrl, wrStatus, softClr, w1cIdx, w1cErr;
   logic                   unusedBits;

   assign pins                 = {Z, B, A};
   assign avs_ctrl_waitrequest = 1'b0;
   assign avs_ctrl_readdata    = readdata_q;
   assign unusedBits           = ^{avs_ctrl_writedata[31:4], avs_ctrl_byteenable[3:1]};

   // Shift each asynchronous pin through its own synchroniser chain
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         for (int i = 0; i < 3; i++) sync_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
      end
   end

   // Last stage of each synchroniser feeds the filter
   always_comb begin
      syncOut = '0;
      for (int i = 0; i < 3; i++) syncOut[i] = sync_q[i][SYNC_STAGES-1];
   end

   // Glitch filter: the output moves only after the synchronised value has
   // disagreed with it for FILTER_LEN cycles in a row; agreeing restarts the count
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         filt_q <= '0;
         for (int i = 0; i < 3; i++) fcnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (syncOut[i] != filt_q[i]) begin
               if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                  filt_q[i] <= syncOut[i];
                  fcnt_q[i] <= '0;
               end else begin
                  fcnt_q[i] <= fcnt_q[i] + FCW'(1);
               end
            end else begin
               fcnt_q[i] <= '0;
            end
         end
      end
   end

   // Quadrature decode and bus write decode. For a single-bit change in the
   // Gray sequence 00->01->11->10, old A xor new B is 1 exactly when moving forward.
   always_comb begin
      enable    = ctrl_q[0];
      zClearEn  = ctrl_q[1];
      invertDir = ctrl_q[2];
      curAB     = {filt_q[0], filt_q[1]};
      bothChg   = &(curAB ^ prevAB_q);
      oneChg    = (curAB != prevAB_q) && !bothChg;
      stepEn    = enable && oneChg;
      errEv     = enable && bothChg;
      countUp   = (prevAB_q[1] ^ curAB[0]) ^ invertDir;
      zRise     = enable && filt_q[2] && !zPrev_q;
      zClear    = zRise && zClearEn;

      wrCtrl    = avs_ctrl_write && (avs_ctrl_address == 3'd1) && avs_ctrl_byteenable[0];
      wrStatus  = avs_ctrl_write && (avs_ctrl_address == 3'd4) && avs_ctrl_byteenable[0];
      softClr   = wrCtrl && avs_ctrl_writedata[3];
      w1cIdx    = wrStatus && avs_ctrl_writedata[1];
      w1cErr    = wrStatus && avs_ctrl_writedata[2];
   end

   // Next-state for counter and status. SOFT_CLR outranks a Z clear, which in
   // turn swallows any step in the same cycle. Hardware sets beat W1C clears.
   always_comb begin
      ctrl_d       = ctrl_q;
      position_d   = position_q;
      indexLatch_d = indexLatch_q;
      dir_d        = dir_q;
      indexSeen_d  = indexSeen_q;
      qerr_d       = qerr_q;
      errCount_d   = errCount_q;

      if (wrCtrl) ctrl_d = avs_ctrl_writedata[2:0];

      if (softClr) begin
         position_d = '0;
      end else if (zClear) begin
         position_d = '0;
      end else if (stepEn) begin
         position_d = countUp ? position_q + CNT_WIDTH'(1) : position_q - CNT_WIDTH'(1);
         dir_d      = countUp;
      end

      if (softClr)    indexLatch_d = '0;
      else if (zRise) indexLatch_d = position_q;

      if (softClr)     indexSeen_d = 1'b0;
      else if (zRise)  indexSeen_d = 1'b1;
      else if (w1cIdx) indexSeen_d = 1'b0;

      if (softClr)     qerr_d = 1'b0;
      else if (errEv)  qerr_d = 1'b1;
      else if (w1cErr) qerr_d = 1'b0;

      if (softClr)                            errCount_d = '0;
      else if (errEv && errCount_q != 16'hFFFF) errCount_d = errCount_q + 16'd1;
   end

   // State registers; the previous A/B and Z values track the filtered pins
   // every cycle regardless of ENABLE so re-enabling never produces a step
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         prevAB_q     <= 2'b00;
         zPrev_q      <= 1'b0;
         ctrl_q       <= '0;
         position_q   <= '0;
         indexLatch_q <= '0;
         dir_q        <= 1'b0;
         indexSeen_q  <= 1'b0;
         qerr_q       <= 1'b0;
         errCount_q   <= '0;
      end else begin
         prevAB_q     <= curAB;
         zPrev_q      <= filt_q[2];
         ctrl_q       <= ctrl_d;
         position_q   <= position_d;
         indexLatch_q <= indexLatch_d;
         dir_q        <= dir_d;
         indexSeen_q  <= indexSeen_d;
         qerr_q       <= qerr_d;
         errCount_q   <= errCount_d;
      end
   end

`ifdef QUADRATURE_ENCODER_X4_IRQ_EN
   logic [2:1] irqMask_q;
   logic       irq_q;

   // Interrupt mask register and registered interrupt output
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         irqMask_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (avs_ctrl_write && (avs_ctrl_address == 3'd6) && avs_ctrl_byteenable[0])
            irqMask_q <= avs_ctrl_writedata[2:1];
         irq_q <= |({qerr_q, indexSeen_q} & irqMask_q);
      end
   end

   assign ins_irq_irq = irq_q;
`endif

   // Read multiplexer; signed casts give the sign-extended readback
   always_comb begin
      readMux = '0;
      case (avs_ctrl_address)
         3'd0: readMux = ID_VALUE;
         3'd1: readMux = {29'd0, ctrl_q};
         3'd2: readMux = 32'($signed(position_q));
         3'd3: readMux = 32'($signed(indexLatch_q));
         3'd4: readMux = {29'd0, qerr_q, indexSeen_q, dir_q};
         3'd5: readMux = {16'd0, errCount_q};
`ifdef QUADRATURE_ENCODER_X4_IRQ_EN
         3'd6: readMux = {29'd0, irqMask_q, 1'b0};
`endif
         default: readMux = '0;
      endcase
   end

   // Registered read data, held between reads
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset)     readdata_q <= '0;
      else if (avs_ctrl_read) readdata_q <= readMux;
   end

endmodule

// File: doc/quadrature_encoder_x4.md
Name: quadrature_encoder_x4

Overview:
- Parametrised quadrature encoder interface on the Qsys Avalon-MM control bus; next generation of the A/B/Z position counter.
- Synchronises and glitch-filters A/B/Z and decodes x4 quadrature into a signed up/down position of configurable width.
- Latches position on index and detects illegal transitions.
- Sits between the motor encoder pins and the Nios/HPS register map.

Parameters:
CNT_WIDTH, 16, position counter width (2..32); readback sign-extended to 32 bits.
SYNC_STAGES, 2, flip-flop synchroniser depth on A/B/Z (>=2).
FILTER_LEN, 4, consecutive stable samples required before a filtered input changes (>=1).
ID_VALUE, 32'hEA680004, value returned at address 0.

Ports:
csi_MCLK_clk  in  1  system clock
rsi_MRST_reset  in  1  reset, asynchronous, active-high
avs_ctrl_writedata  in  32  write data
avs_ctrl_readdata  out  32  read data, registered
avs_ctrl_byteenable  in  4  byte enables; a byte is written only if its enable is set
avs_ctrl_address  in  3  word address
avs_ctrl_write  in  1  write strobe
avs_ctrl_read  in  1  read strobe
avs_ctrl_waitrequest  out  1  constant 0
A  in  1  encoder channel A, asynchronous
B  in  1  encoder channel B, asynchronous
Z  in  1  encoder index, asynchronous

Behaviour:
- Reset: all registers 0, readdata 0, filtered A/B/Z outputs 0, previous-state register 00.
- Register map:
  - 0 ID (RO).
  - 1 CTRL: bit0 ENABLE, bit1 Z_CLEAR_EN, bit2 INVERT_DIR, bit3 SOFT_CLR (write-1 pulse, reads 0).
  - 2 POSITION (RO, sign-extended).
  - 3 INDEX_LATCH (RO, sign-extended).
  - 4 STATUS: bit0 DIR (RO, last counted direction, 1 = up), bit1 INDEX_SEEN (sticky, W1C), bit2 QERR (sticky, W1C).
  - 5 ERR_COUNT (RO, 16-bit saturating, cleared by SOFT_CLR).
  - 6, 7: read 0.
- Read latency: 1 cycle. readdata updates on the clock after the address is sampled with avs_ctrl_read high; it holds its value otherwise.
- Synchroniser: SYNC_STAGES flops per input.
- Filter: per-input counter. The filtered output takes the synchronised value once that value has differed from the current output for FILTER_LEN consecutive cycles. Any bounce back resets the counter.
- Decode, evaluated when ENABLE=1 on every change of filtered {A,B} against the previous state:
  - Forward sequence 00->01->11->10->00 (bit order {A,B}) gives +1.
  - Reverse sequence gives -1.
  - INVERT_DIR swaps the sign.
  - Both bits changing in one cycle: no count, QERR set, ERR_COUNT+1.
  - The previous state always updates, including when ENABLE=0. Re-enabling therefore never produces a spurious step.
- Position arithmetic: two's complement, CNT_WIDTH bits, wraps silently (max+1 -> min, min-1 -> max).
- Index, on a filtered Z rising edge while ENABLE=1:
  - INDEX_LATCH captures POSITION as it stands before any update in that cycle.
  - INDEX_SEEN is set.
  - If Z_CLEAR_EN=1, POSITION becomes 0.
- Priority on simultaneous events, highest first: SOFT_CLR > Z clear > count step. A step coincident with a Z clear is discarded.
- W1C racing a hardware set in the same cycle: the set wins.
- SOFT_CLR clears POSITION, INDEX_LATCH, ERR_COUNT and the STATUS sticky bits.
- Pin-to-POSITION latency: SYNC_STAGES + FILTER_LEN + 1 clocks after the input edge.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous reset).

Optional Feature:
- Macro: QUADRATURE_ENCODER_X4_IRQ_EN.
- When defined:
  - Adds output port ins_irq_irq (1 bit, registered, reset 0).
  - Address 6 becomes IRQ_MASK (bits 1:2 map to INDEX_SEEN and QERR; reset 0).
  - ins_irq_irq = OR of (STATUS[2:1] & IRQ_MASK[2:1]), one clock after the status bit sets.
  - Clearing the status bit via W1C deasserts the irq on the following clock.
- When undefined: no irq port, and address 6 reads 0 and ignores writes.

Test Plan:
- Reset, then read address 0 -> 32'hEA680004; addresses 1-5 -> 0; waitrequest always 0.
- ENABLE=1, drive 10 forward cycles (40 transitions, each held >FILTER_LEN clocks) -> POSITION=40, DIR=1. Then 12 reverse transitions -> POSITION=28, DIR=0.
- From POSITION=0, apply 1 reverse step with CNT_WIDTH=16 -> readback 32'hFFFFFFFF. Preload to 32767 and apply +1 -> 32'hFFFF8000.
- Glitch on A of FILTER_LEN-1 clocks -> POSITION unchanged. Swap A and B together -> QERR=1, ERR_COUNT=1, POSITION unchanged. Write 4 to STATUS -> QERR=0.
- POSITION=100, Z_CLEAR_EN=1, Z rising coincident with a forward step -> INDEX_LATCH=100, POSITION=0, INDEX_SEEN=1.
- Assert reset mid-count at POSITION=57 -> all registers read 0 after release. With IRQ_EN defined and mask=2, Z pulse -> ins_irq_irq=1; W1C bit1 -> irq=0.
